// File: rtl/multi_edge_trigger.sv
// rtl/multi_edge_trigger.sv - per-channel synchronised edge trigger with holdoff and event counters
module multi_edge_trigger #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_W      = 16,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         start,
  input  logic [2*N_CH-1:0]       mode,
  input  logic [HOLD_W-1:0]       holdoff,
  input  logic                    cnt_clr,
  output logic [N_CH-1:0]         trigger,
  output logic                    trig_any,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH*CNT_W-1:0]   evt_cnt
);

  typedef enum logic {
    ST_ARMED   = 1'b0,
    ST_HOLDOFF = 1'b1
  } ch_state_e;

  // Warm-up covers the sync chain refill plus the p stage, so a level held
  // through reset is never mistaken for an edge.
  localparam logic [2:0] WARM_INIT = 3'(SYNC_STAGES + 1);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Synchroniser chain: stage 0 samples the raw input, last stage is s.
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  s_w;
  logic [N_CH-1:0]                  p_q;

  logic [2:0]                       warm_q;
  logic [2:0]                       warm_d;
  logic                             warm_done;

  logic [N_CH-1:0]                  rise_w;
  logic [N_CH-1:0]                  fall_w;
  logic [N_CH-1:0]                  qual_w;

  ch_state_e                        state_q [N_CH];
  ch_state_e                        state_d [N_CH];
  logic [HOLD_W-1:0]                hc_q    [N_CH];
  logic [HOLD_W-1:0]                hc_d    [N_CH];

  logic [N_CH-1:0]                  trigger_q;
  logic [N_CH-1:0]                  trigger_d;

  logic [CNT_W-1:0]                 cnt_q   [N_CH];
  logic [CNT_W-1:0]                 cnt_d   [N_CH];

  assign s_w       = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == 3'd0);

  // Shift every input through the synchroniser and keep one delayed copy of s.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      p_q    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], start};
      p_q    <= s_w;
    end
  end

  // Count down the post-reset window during which edges are not qualified.
  always_comb begin
    warm_d = warm_q;
    if (!warm_done) begin
      warm_d = warm_q - 3'd1;
    end
  end

  // Warm-up counter register, reloaded on every reset clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q <= WARM_INIT;
    end else begin
      warm_q <= warm_d;
    end
  end

  // Per-channel edge qualifier selected by the live mode bits.
  always_comb begin
    rise_w = s_w & ~p_q;
    fall_w = ~s_w & p_q;
    qual_w = '0;
    for (int i = 0; i < N_CH; i++) begin
      unique case (mode[2*i +: 2])
        MODE_OFF:  qual_w[i] = 1'b0;
        MODE_RISE: qual_w[i] = rise_w[i];
        MODE_FALL: qual_w[i] = fall_w[i];
        MODE_BOTH: qual_w[i] = rise_w[i] | fall_w[i];
        default:   qual_w[i] = 1'b0;
      endcase
    end
  end

  // Channel FSM next state: fire from ARMED, otherwise count down the holdoff.
  // holdoff is only looked at on the firing clock so later changes cannot
  // stretch or shorten a holdoff already running.
  always_comb begin
    trigger_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      hc_d[i]    = hc_q[i];
      unique case (state_q[i])
        ST_ARMED: begin
          if (qual_w[i] && warm_done) begin
            trigger_d[i] = 1'b1;
            hc_d[i]      = holdoff;
            if (holdoff != '0) begin
              state_d[i] = ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          // Edges are dropped here, not remembered for later.
          if ((hc_q[i] == '0) || (hc_q[i] == HOLD_W'(1))) begin
            hc_d[i]    = '0;
            state_d[i] = ST_ARMED;
          end else begin
            hc_d[i] = hc_q[i] - HOLD_W'(1);
          end
        end
        default: begin
          hc_d[i]    = '0;
          state_d[i] = ST_ARMED;
        end
      endcase
    end
  end

  // Channel state, holdoff counters and the registered trigger pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_ARMED;
        hc_q[i]    <= '0;
      end
      trigger_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        hc_q[i]    <= hc_d[i];
      end
      trigger_q <= trigger_d;
    end
  end

  // Event counters advance at the end of each trigger cycle and saturate;
  // a clear in that same cycle still records the trigger being retired.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = CNT_W'(trigger_q[i]);
      end else if (trigger_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Output mapping.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      busy[i] = (state_q[i] == ST_HOLDOFF);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
    assign evt_cnt[CNT_W*g +: CNT_W] = cnt_q[g];
  end

  assign trigger  = trigger_q;
  assign trig_any = |trigger_q;

endmodule

// File: tb/tb_multi_edge_trigger.sv
// tb/tb_multi_edge_trigger.sv - directed self-checking bench for multi_edge_trigger
module tb_multi_edge_trigger;

  localparam int N_CH        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD_W      = 16;
  localparam int CNT_W       = 4;

  logic                  clk;
  logic                  rst;
  logic [N_CH-1:0]       start;
  logic [2*N_CH-1:0]     mode;
  logic [HOLD_W-1:0]     holdoff;
  logic                  cnt_clr;
  logic [N_CH-1:0]       trigger;
  logic                  trig_any;
  logic [N_CH-1:0]       busy;
  logic [N_CH*CNT_W-1:0] evt_cnt;

  int n_checks;
  int n_fail;

  multi_edge_trigger #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .HOLD_W      (HOLD_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .holdoff  (holdoff),
    .cnt_clr  (cnt_clr),
    .trigger  (trigger),
    .trig_any (trig_any),
    .busy     (busy),
    .evt_cnt  (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = '0;
    mode     = '0;
    holdoff  = '0;
    cnt_clr  = 1'b0;

    // Reset state
    ticks(3);
    chk("rst_trigger", 64'(trigger), 64'h0);
    chk("rst_any", 64'(trig_any), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_cnt", 64'(evt_cnt), 64'h0);
    rst = 1'b0;
    ticks(5);

    // Latency: rising on ch0, holdoff 0
    mode  = 8'b00_00_00_01;
    start = 4'b0001;
    tick();
    chk("lat_e0", 64'(trigger), 64'h0);
    tick();
    chk("lat_e1", 64'(trigger), 64'h0);
    tick();
    chk("lat_e2_trig", 64'(trigger), 64'h1);
    chk("lat_e2_any", 64'(trig_any), 64'h1);
    tick();
    chk("lat_e3_trig", 64'(trigger), 64'h0);
    chk("lat_e3_any", 64'(trig_any), 64'h0);
    chk("lat_cnt0", 64'(evt_cnt), 64'h0001);

    // Both edges, holdoff 3, input toggling each clock
    start = '0;
    mode  = 8'b00_00_00_11;
    holdoff = 16'd3;
    do_reset();
    ticks(5);
    for (int t = 0; t < 20; t++) begin
      start[0] = ~start[0];
      tick();
      chk($sformatf("hold_trig_t%0d", t), 64'(trigger[0]),
          64'((t >= 2) && ((t - 2) % 4 == 0)));
      chk($sformatf("hold_busy_t%0d", t), 64'(busy[0]),
          64'((t >= 2) && ((t - 2) % 4 != 3)));
    end
    chk("hold_cnt0", 64'(evt_cnt[3:0]), 64'd5);

    // Falling mode on ch1, level held high through reset
    mode    = 8'b00_00_10_00;
    holdoff = '0;
    start   = 4'b0010;
    do_reset();
    for (int t = 0; t < 20; t++) begin
      tick();
      chk($sformatf("warm_t%0d", t), 64'(trigger), 64'h0);
    end
    start = 4'b0000;
    tick();
    chk("fall_e0", 64'(trigger), 64'h0);
    tick();
    chk("fall_e1", 64'(trigger), 64'h0);
    tick();
    chk("fall_e2", 64'(trigger), 64'h2);
    tick();
    chk("fall_e3", 64'(trigger), 64'h0);
    chk("fall_cnt", 64'(evt_cnt), 64'h0010);

    // Saturation on ch2 with a 4-bit counter
    mode = 8'b00_01_00_00;
    do_reset();
    ticks(5);
    for (int n = 0; n < 20; n++) begin
      start[2] = 1'b1;
      ticks(3);
      start[2] = 1'b0;
      ticks(3);
    end
    chk("sat_cnt2", 64'(evt_cnt[11:8]), 64'd15);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt2", 64'(evt_cnt[11:8]), 64'd0);
    start[2] = 1'b1;
    ticks(3);
    chk("clr_trig2", 64'(trigger), 64'h4);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_coinc_cnt2", 64'(evt_cnt[11:8]), 64'd1);
    tick();
    chk("clr_after_cnt2", 64'(evt_cnt[11:8]), 64'd1);

    // Reset aborting a long holdoff on ch3
    start   = '0;
    mode    = 8'b01_00_00_00;
    holdoff = 16'd100;
    do_reset();
    ticks(5);
    start[3] = 1'b1;
    ticks(3);
    chk("ab_trig3", 64'(trigger), 64'h8);
    tick();
    chk("ab_busy3", 64'(busy), 64'h8);
    mode = '0;
    ticks(3);
    chk("ab_mode_keep_busy", 64'(busy), 64'h8);
    mode = 8'b01_00_00_00;
    rst  = 1'b1;
    tick();
    chk("ab_rst_busy", 64'(busy), 64'h0);
    chk("ab_rst_cnt", 64'(evt_cnt), 64'h0);
    chk("ab_rst_trig", 64'(trigger), 64'h0);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("ab_warm_t%0d", t), 64'(trigger), 64'h0);
    end
    start[3] = 1'b0;
    ticks(4);
    start[3] = 1'b1;
    ticks(2);
    chk("ab_re_e1", 64'(trigger), 64'h0);
    tick();
    chk("ab_re_trig3", 64'(trigger), 64'h8);
    tick();
    chk("ab_re_busy3", 64'(busy), 64'h8);
    chk("ab_re_cnt3", 64'(evt_cnt), 64'h1000);

    // Common rising edge, ch1 switched off
    start   = '0;
    mode    = 8'b01_01_00_01;
    holdoff = '0;
    do_reset();
    ticks(5);
    start = 4'hF;
    ticks(2);
    chk("all_e1", 64'(trigger), 64'h0);
    tick();
    chk("all_trig", 64'(trigger), 64'hD);
    chk("all_any", 64'(trig_any), 64'h1);
    tick();
    chk("all_cnt", 64'(evt_cnt), 64'h1101);
    start = 4'h0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("all_fall_t%0d", t), 64'(trigger), 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_edge_trigger.md
MULTI_EDGE_TRIGGER -- requirements
Module: multi_edge_trigger

Interface
REQ-001 Parameter N_CH, default 4: number of independent trigger channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per input (2..4).
REQ-003 Parameter HOLD_W, default 16: holdoff counter width.
REQ-004 Parameter CNT_W, default 16: per-channel event counter width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 start  input  N_CH  asynchronous level inputs, one per channel.
REQ-008 mode  input  2*N_CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 holdoff  input  HOLD_W  dead time in clocks after each trigger, shared by all channels.
REQ-010 cnt_clr  input  1  synchronous clear of all event counters.
REQ-011 trigger  output  N_CH  one-clock trigger pulse per channel, registered.
REQ-012 trig_any  output  1  OR of trigger bits.
REQ-013 busy  output  N_CH  channel is in holdoff.
REQ-014 evt_cnt  output  N_CH*CNT_W  saturating trigger count, channel i at [CNT_W*i +: CNT_W].

Function
REQ-015 Each start bit SHALL pass through SYNC_STAGES flops; s_i is the last stage, p_i is s_i delayed one clock.
REQ-016 Edge qualifier: rising = s_i & ~p_i; falling = ~s_i & p_i; selected per mode_i; mode 00 qualifies nothing.
REQ-017 Each channel SHALL hold a state ARMED or HOLDOFF, plus a HOLD_W-bit counter hc_i.
REQ-018 ARMED with qualified edge: trigger_i SHALL be 1 in the next cycle; hc_i <= holdoff; state -> HOLDOFF if holdoff != 0, else stays ARMED.
REQ-019 HOLDOFF: hc_i decrements each clock; qualified edges are ignored (not queued); when hc_i reaches 0 the state SHALL return to ARMED in that same edge.
REQ-020 holdoff SHALL be sampled only at trigger time; changes during HOLDOFF do not alter the running count.
REQ-021 Minimum trigger spacing on one channel SHALL be holdoff+1 clocks; holdoff=0 permits triggers on consecutive clocks (mode 11, input toggling every clock).
REQ-022 Latency: input change sampled by the first sync flop at edge k SHALL produce trigger_i high in the cycle after edge k+SYNC_STAGES, for exactly one clock.
REQ-023 busy_i SHALL equal (state_i == HOLDOFF).
REQ-024 trig_any SHALL be the combinational OR of the registered trigger vector (no extra latency).
REQ-025 evt_cnt_i SHALL increment by 1 in the cycle trigger_i is 1, saturating at 2^CNT_W-1.
REQ-026 cnt_clr SHALL zero all counters; cnt_clr coincident with trigger_i SHALL leave evt_cnt_i = 1.
REQ-027 Mode change SHALL take effect on the next qualifier evaluation; it SHALL NOT abort a running holdoff.
REQ-028 Channels SHALL be fully independent; simultaneous triggers on all channels are legal.

Reset
REQ-029 While rst=1 in a clock: sync flops, p_i, trigger, hc_i, evt_cnt cleared to 0; state ARMED; busy 0; trig_any 0.
REQ-030 After rst deasserts, qualified edges SHALL be suppressed for SYNC_STAGES+1 clocks (warm-up), so an input held high through reset produces no trigger.
REQ-031 rst asserted mid-holdoff SHALL abort holdoff and return to the REQ-029 state at that edge.

Verification
REQ-032 SYNC_STAGES=2, mode0=01, holdoff=0: start0 0->1 sampled at edge 10 -> trigger0 high only in cycle after edge 12, evt_cnt0=1, trig_any mirrors.
REQ-033 mode0=11, holdoff=3, start0 toggled every clock -> triggers exactly 4 clocks apart, busy0 high 3 clocks after each, no queued triggers.
REQ-034 mode1=10, start1 held 1 through reset, released 0 after 20 clocks -> no trigger during warm-up, single trigger on falling edge.
REQ-035 CNT_W=4, 20 spaced rising edges on channel 2 -> evt_cnt2 stops at 15; cnt_clr coincident with a trigger -> evt_cnt2=1.
REQ-036 rst pulsed while channel 3 busy with holdoff=100 -> busy3=0, hc cleared, next edge after warm-up triggers normally.
REQ-037 All channels mode 01, common rising edge -> all trigger bits high in the same cycle, each counter +1; mode 00 channel never triggers.
